// File: rtl/cache_pkg.sv
// Shared types and address helpers for the cache line refill controller.
package cache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBeat,
    StDone
  } fill_state_e;

  // Number of byte-offset bits covered by one cache line.
  function automatic int unsigned off_bits(input int unsigned words, input int unsigned data_w);
    return $clog2(words) + $clog2(data_w / 8);
  endfunction

  function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned off);
    return addr & ~((64'd1 << off) - 64'd1);
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Line-fill beat counter: loadable word index that wraps modulo WORDS plus a beat count
// that flags the final beat of the line.
module beat_counter #(
  parameter int unsigned WORDS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_load,
  input  logic [$clog2(WORDS)-1:0] i_start,
  input  logic                     i_en,
  output logic [$clog2(WORDS)-1:0] o_idx,
  output logic                     o_last_beat
);

  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam logic [IDX_W:0] LAST_CNT = (IDX_W + 1)'(WORDS - 1);

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W:0]   r_count;

  // WORDS is a power of two, so the index wraps by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_idx   <= i_start;
      r_count <= '0;
    end else if (i_en) begin
      r_idx   <= r_idx + IDX_W'(1);
      r_count <= r_count + (IDX_W + 1)'(1);
    end
  end

  assign o_idx       = r_idx;
  assign o_last_beat = i_en && (r_count == LAST_CNT);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache line refill controller: one miss -> one burst read -> WORDS array writes -> fill_done.
// Define CACHE_FILL_CWF_EN for critical-word-first bursts starting at the missing word.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_miss_valid,
  input  logic [ADDR_W-1:0]        i_miss_addr,
  output logic                     o_miss_ready,
  output logic                     o_mem_req_valid,
  output logic [ADDR_W-1:0]        o_mem_req_addr,
  input  logic                     i_mem_req_ready,
  input  logic                     i_mem_rsp_valid,
  input  logic [DATA_W-1:0]        i_mem_rsp_data,
  output logic                     o_arr_we,
  output logic [$clog2(WORDS)-1:0] o_arr_word,
  output logic [DATA_W-1:0]        o_arr_wdata,
  output logic                     o_fill_done,
  output logic [ADDR_W-1:0]        o_fill_line,
  output logic                     o_fill_busy
);

  localparam int unsigned IDX_W  = $clog2(WORDS);
  localparam int unsigned OFF    = off_bits(WORDS, DATA_W);
  localparam int unsigned BYTE_W = OFF - IDX_W;

  fill_state_e       r_state, w_state_next;
  logic [ADDR_W-1:0] r_line, r_req_addr;
  logic [ADDR_W-1:0] w_line, w_req_addr;
  logic [IDX_W-1:0]  w_start, w_idx;
  logic              w_accept, w_beat_en, w_last_beat;

  assign w_line = ADDR_W'(line_align(64'(i_miss_addr), OFF));

`ifdef CACHE_FILL_CWF_EN
  assign w_start    = i_miss_addr[OFF-1:BYTE_W];
  assign w_req_addr = w_line | (ADDR_W'(w_start) << BYTE_W);
`else
  assign w_start    = '0;
  assign w_req_addr = w_line;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_line     <= '0;
      r_req_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_line     <= w_line;
        r_req_addr <= w_req_addr;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_accept        = 1'b0;
    w_beat_en       = 1'b0;
    o_miss_ready    = 1'b0;
    o_mem_req_valid = 1'b0;
    o_arr_we        = 1'b0;
    o_fill_done     = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_miss_ready = 1'b1;
        if (i_miss_valid) begin
          w_accept     = 1'b1;
          w_state_next = StReq;
        end
      end
      StReq: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) w_state_next = StBeat;
      end
      StBeat: begin
        if (i_mem_rsp_valid) begin
          o_arr_we  = 1'b1;
          w_beat_en = 1'b1;
          if (w_last_beat) w_state_next = StDone;
        end
      end
      StDone: begin
        o_fill_done  = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  beat_counter #(
    .WORDS(WORDS)
  ) u_beat_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_start    (w_start),
    .i_en       (w_beat_en),
    .o_idx      (w_idx),
    .o_last_beat(w_last_beat)
  );

  // Index and data are gated so the array port is quiet whenever no write is issued.
  assign o_arr_word     = o_arr_we ? w_idx : '0;
  assign o_arr_wdata    = o_arr_we ? i_mem_rsp_data : '0;
  assign o_mem_req_addr = r_req_addr;
  assign o_fill_line    = r_line;
  assign o_fill_busy    = (r_state != StIdle);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed self-checking bench for cache_fill_ctrl (WORDS=8, DATA_W=32, ADDR_W=32).
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        arr_we;
  logic [2:0]  arr_word;
  logic [31:0] arr_wdata;
  logic        fill_done;
  logic [31:0] fill_line;
  logic        fill_busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  cache_fill_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .WORDS (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_miss_valid   (miss_valid),
    .i_miss_addr    (miss_addr),
    .o_miss_ready   (miss_ready),
    .o_mem_req_valid(mem_req_valid),
    .o_mem_req_addr (mem_req_addr),
    .i_mem_req_ready(mem_req_ready),
    .i_mem_rsp_valid(mem_rsp_valid),
    .i_mem_rsp_data (mem_rsp_data),
    .o_arr_we       (arr_we),
    .o_arr_word     (arr_word),
    .o_arr_wdata    (arr_wdata),
    .o_fill_done    (fill_done),
    .o_fill_line    (fill_line),
    .o_fill_busy    (fill_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_miss_ready"}, miss_ready, 1);
    check_eq({tag, "_req_valid"}, mem_req_valid, 0);
    check_eq({tag, "_req_addr"}, mem_req_addr, 0);
    check_eq({tag, "_arr_we"}, arr_we, 0);
    check_eq({tag, "_arr_word"}, arr_word, 0);
    check_eq({tag, "_arr_wdata"}, arr_wdata, 0);
    check_eq({tag, "_fill_done"}, fill_done, 0);
    check_eq({tag, "_fill_line"}, fill_line, 0);
    check_eq({tag, "_fill_busy"}, fill_busy, 0);
  endtask

  // Memory model answers one cycle after it accepts the request, then follows the gap list
  // (4 bits of extra idle cycles per beat). hold keeps a second miss pending during the fill.
  task automatic do_fill(input logic [31:0] addr, input int unsigned req_wait,
                         input logic [31:0] gaps, input bit hold, input logic [31:0] addr2);
    logic [31:0] exp_line, exp_req, data;
    int unsigned start, nwr, cyc, g;
    exp_line = addr & ~32'h1F;
`ifdef CACHE_FILL_CWF_EN
    start = (addr >> 2) & 32'd7;
`else
    start = 0;
`endif
    exp_req = exp_line | (start << 2);
    nwr = 0;
    miss_valid = 1'b1;
    miss_addr = addr;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("accept_ready", miss_ready, 1);
    step();
    cyc = 1;
    miss_valid = hold;
    miss_addr = addr2;
    for (int w = 0; w <= int'(req_wait); w++) begin
      mem_req_ready = (w == int'(req_wait));
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'hBAD0_0000 | w;
      #1;
      check_eq("req_valid", mem_req_valid, 1);
      check_eq("req_addr", mem_req_addr, exp_req);
      check_eq("req_no_we", arr_we, 0);
      check_eq("req_miss_ready", miss_ready, 0);
      check_eq("req_fill_line", fill_line, exp_line);
      check_eq("req_busy", fill_busy, 1);
      step();
      cyc++;
    end
    mem_req_ready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      g = gaps[4*b +: 4] + ((b == 0) ? 1 : 0);
      for (int k = 0; k < int'(g); k++) begin
        mem_rsp_valid = 1'b0;
        #1;
        check_eq("gap_no_we", arr_we, 0);
        check_eq("gap_wdata", arr_wdata, 0);
        check_eq("gap_req_valid", mem_req_valid, 0);
        check_eq("gap_miss_ready", miss_ready, 0);
        step();
        cyc++;
      end
      data = 32'hC0DE_0000 | (b << 8) | start;
      mem_rsp_valid = 1'b1;
      mem_rsp_data = data;
      #1;
      check_eq("beat_we", arr_we, 1);
      check_eq("beat_word", arr_word, (start + b) % 8);
      check_eq("beat_wdata", arr_wdata, data);
      check_eq("beat_no_done", fill_done, 0);
      check_eq("beat_miss_ready", miss_ready, 0);
      nwr += arr_we;
      step();
      cyc++;
    end
    mem_rsp_valid = 1'b0;
    #1;
    check_eq("write_count", nwr, 8);
    check_eq("done_pulse", fill_done, 1);
    check_eq("done_miss_ready", miss_ready, 0);
    check_eq("done_busy", fill_busy, 1);
    check_eq("done_no_we", arr_we, 0);
    if (req_wait == 0 && gaps == 0) check_eq("done_latency", cyc, 11);
    step();
    #1;
    check_eq("post_done_low", fill_done, 0);
    check_eq("post_miss_ready", miss_ready, 1);
    check_eq("post_fill_line", fill_line, exp_line);
  endtask

  initial begin
    reset = 1'b1;
    miss_valid = 1'b0;
    miss_addr = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    step();
    step();
    check_reset_vals("rst");
    reset = 1'b0;

    // Spurious beats while idle
    for (int i = 0; i < 2; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'hDEAD_BEEF;
      #1;
      check_eq("idle_no_we", arr_we, 0);
      check_eq("idle_wdata", arr_wdata, 0);
      step();
    end
    mem_rsp_valid = 1'b0;

    do_fill(32'h0000_1234, 0, 32'h0, 1'b0, 32'h0);
    do_fill(32'h0000_0ABC, 4, 32'h2103_0120, 1'b0, 32'h0);
    do_fill(32'h4000_0040, 0, 32'h0000_1000, 1'b1, 32'h0000_8F6C);
    do_fill(32'h0000_8F6C, 0, 32'h0, 1'b0, 32'h0);

    // Reset after the third beat of a fill
    miss_valid = 1'b1;
    miss_addr = 32'h0000_2468;
    #1;
    check_eq("rf_accept", miss_ready, 1);
    step();
    miss_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    check_eq("rf_req_valid", mem_req_valid, 1);
    step();
    mem_req_ready = 1'b0;
    step();
    for (int b = 0; b < 3; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'h5A5A_0000 | b;
      #1;
      check_eq("rf_pre_we", arr_we, 1);
      step();
    end
    reset = 1'b1;
    mem_rsp_data = 32'h5A5A_0003;
    step();
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h5A5A_0004;
    #1;
    check_reset_vals("rf_post");
    step();
    for (int b = 5; b < 9; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'h5A5A_0000 | b;
      #1;
      check_eq("rf_late_we", arr_we, 0);
      check_eq("rf_no_done", fill_done, 0);
      check_eq("rf_no_req", mem_req_valid, 0);
      step();
    end
    mem_rsp_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
